// File: rtl/scalar_mul_ctrl.sv
// scalar_mul_ctrl: MSB-first double-and-add sequencer that drives an external point-add unit.
// Defining SMUL_CYCLE_CNT_EN adds the o_cycles busy-cycle counter.
module scalar_mul_ctrl #(
    parameter int NBITS = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [NBITS-1:0] i_scalar,
    input  logic [254:0]     i_px,
    input  logic [254:0]     i_py,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_zero,
    output logic [254:0]     o_x,
    output logic [254:0]     o_y,
    output logic [254:0]     o_z,
    output logic [254:0]     o_t,
    output logic             o_pa_start,
    output logic             o_pa_doubling,
    output logic             o_pa_initial,
    output logic [254:0]     o_pa_x1,
    output logic [254:0]     o_pa_y1,
    output logic [254:0]     o_pa_z1,
    output logic [254:0]     o_pa_t1,
    output logic [254:0]     o_pa_x2,
    output logic [254:0]     o_pa_y2,
    output logic [254:0]     o_pa_z2,
    output logic [254:0]     o_pa_t2,
    input  logic [254:0]     i_pa_x3,
    input  logic [254:0]     i_pa_y3,
    input  logic [254:0]     i_pa_z3,
    input  logic [254:0]     i_pa_t3,
    input  logic             i_pa_finished,
`ifdef SMUL_CYCLE_CNT_EN
    output logic [31:0]      o_cycles,
`endif
    output logic [2:0]       o_state
);
    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_SCAN, S_DBL, S_ADD, S_DONE} state_t;
    typedef struct packed { logic [254:0] x, y, z, t; } pt_t;

    // Point-add handshake: o_pa_start is a single-cycle command strobe with operands and
    // mode registered alongside it and held until the unit answers; i_pa_finished is
    // accepted only while a command is outstanding (never in the strobe cycle itself).
    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [NBITS-1:0] k_r, k_n;
    pt_t              q, q_n, b, b_n, op1, op1_n, op2, op2_n, res, res_n;
    pt_t              pa_res;
    logic             pa_start, pa_start_n, dbl, dbl_n, init, init_n;
    logic             busy, busy_n, done, done_n, zero, zero_n;
    logic             pa_ack, go_dbl, go_add, go_done, zero_hit;

    assign pa_res = {i_pa_x3, i_pa_y3, i_pa_z3, i_pa_t3};
    assign pa_ack = !pa_start && i_pa_finished;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            idx      <= IW'(NBITS - 1);
            k_r      <= '0;
            q        <= '0;
            b        <= '0;
            op1      <= '0;
            op2      <= '0;
            res      <= '0;
            pa_start <= 1'b0;
            dbl      <= 1'b0;
            init     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            zero     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            k_r      <= k_n;
            q        <= q_n;
            b        <= b_n;
            op1      <= op1_n;
            op2      <= op2_n;
            res      <= res_n;
            pa_start <= pa_start_n;
            dbl      <= dbl_n;
            init     <= init_n;
            busy     <= busy_n;
            done     <= done_n;
            zero     <= zero_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        k_n        = k_r;
        q_n        = q;
        b_n        = b;
        op1_n      = op1;
        op2_n      = op2;
        res_n      = res;
        pa_start_n = 1'b0;
        dbl_n      = dbl;
        init_n     = init;
        busy_n     = busy;
        done_n     = 1'b0;
        zero_n     = 1'b0;
        go_dbl     = 1'b0;
        go_add     = 1'b0;
        go_done    = 1'b0;
        zero_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    k_n        = i_scalar;
                    idx_n      = IW'(NBITS - 1);
                    busy_n     = 1'b1;
                    pa_start_n = 1'b1;
                    init_n     = 1'b1;
                    dbl_n      = 1'b0;
                    op1_n      = {i_px, i_py, 255'd0, 255'd0};
                    op2_n      = '0;
                    state_n    = S_CONV;
                end
            end
            S_CONV: begin
                if (pa_ack) begin
                    b_n     = pa_res;
                    state_n = S_SCAN;
                end
            end
            S_SCAN: begin
                // Leading zeros are skipped one bit per cycle without touching the point-add unit.
                if (k_r[idx]) begin
                    q_n = b;
                    if (idx != '0) go_dbl = 1'b1;
                    else           go_done = 1'b1;
                end else if (idx != '0) begin
                    idx_n = idx - IW'(1);
                end else begin
                    go_done  = 1'b1;
                    zero_hit = 1'b1;
                end
            end
            S_DBL: begin
                if (pa_ack) begin
                    q_n = pa_res;
                    if (k_r[idx])       go_add  = 1'b1;
                    else if (idx != '0) go_dbl  = 1'b1;
                    else                go_done = 1'b1;
                end
            end
            S_ADD: begin
                if (pa_ack) begin
                    q_n = pa_res;
                    if (idx != '0) go_dbl  = 1'b1;
                    else           go_done = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (go_dbl) begin
            state_n    = S_DBL;
            idx_n      = idx - IW'(1);
            pa_start_n = 1'b1;
            dbl_n      = 1'b1;
            init_n     = 1'b0;
            op1_n      = q_n;
            op2_n      = q_n;
        end
        if (go_add) begin
            state_n    = S_ADD;
            pa_start_n = 1'b1;
            dbl_n      = 1'b0;
            init_n     = 1'b0;
            op1_n      = q_n;
            op2_n      = b;
        end
        if (go_done) begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            zero_n  = zero_hit;
            res_n   = zero_hit ? '0 : q_n;
        end
    end

`ifdef SMUL_CYCLE_CNT_EN
    logic [31:0] cycles;
    always_ff @(posedge i_clk) begin
        if (i_rst)                         cycles <= '0;
        else if (state == S_IDLE && i_start) cycles <= '0;
        else if (busy && cycles != '1)     cycles <= cycles + 32'd1;
    end
    assign o_cycles = cycles;
`endif

    assign o_state       = state;
    assign o_busy        = busy;
    assign o_done        = done;
    assign o_zero        = zero;
    assign o_x           = res.x;
    assign o_y           = res.y;
    assign o_z           = res.z;
    assign o_t           = res.t;
    assign o_pa_start    = pa_start;
    assign o_pa_doubling = dbl;
    assign o_pa_initial  = init;
    assign o_pa_x1       = op1.x;
    assign o_pa_y1       = op1.y;
    assign o_pa_z1       = op1.z;
    assign o_pa_t1       = op1.t;
    assign o_pa_x2       = op2.x;
    assign o_pa_y2       = op2.y;
    assign o_pa_z2       = op2.z;
    assign o_pa_t2       = op2.t;
endmodule
